// File: rtl/cmd_write_pkg.sv
// Shared SD command-path definitions: frame geometry, FSM states, CRC7 helpers.
// Used by both the command writer and the response receiver.
package cmd_write_pkg;

  localparam int unsigned FRAME_LEN     = 48;
  localparam int unsigned CNT_W         = 6;
  localparam int unsigned CRC_W         = 7;
  localparam int unsigned CRC_START_BIT = 40;
  localparam int unsigned CRC_END_BIT   = 46;
  localparam int unsigned GAP_LEN       = 2;
  localparam int unsigned GAP_W         = 1;
  localparam int unsigned INDEX_W       = 6;
  localparam int unsigned ARG_W         = 32;

  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_GAP  = 2'd2
  } sd_state_e;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [ARG_W-1:0]   arg;
    logic               rsp_expected;
  } cmd_req_t;

  // One serial step of the x^7+x^3+1 CRC, MSB-first.
  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                 input logic             bit_in);
    logic fb;
    fb = bit_in ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : CRC_W'(0));
  endfunction

  // Header bit k (0..39) of a command frame: start, transmission, index, argument.
  function automatic logic frame_bit(input logic [CNT_W-1:0]   k,
                                     input logic [INDEX_W-1:0] index,
                                     input logic [ARG_W-1:0]   arg);
    logic b;
    if (k == CNT_W'(0))                     b = 1'b0;
    else if (k == CNT_W'(1))                b = 1'b1;
    else if (k < CNT_W'(2 + INDEX_W))       b = index[3'(CNT_W'(1 + INDEX_W) - k)];
    else if (k < CNT_W'(CRC_START_BIT))     b = arg[5'(CNT_W'(CRC_START_BIT - 1) - k)];
    else                                    b = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/cmd_write_if.sv
// Command-writer request/line bundle: host-side request plus CMD line and status.
interface cmd_write_if;
  import cmd_write_pkg::*;

  logic               start_tx_i;
  logic [INDEX_W-1:0] cmd_index_i;
  logic [ARG_W-1:0]   cmd_arg_i;
  logic               rsp_expected_i;
  logic               cmd_o;
  logic               cmd_en_o;
  logic               busy_o;
  logic               done_o;
  logic               start_listening_o;

  modport master (
    output start_tx_i, cmd_index_i, cmd_arg_i, rsp_expected_i,
    input  cmd_o, cmd_en_o, busy_o, done_o, start_listening_o
  );

  modport slave (
    input  start_tx_i, cmd_index_i, cmd_arg_i, rsp_expected_i,
    output cmd_o, cmd_en_o, busy_o, done_o, start_listening_o
  );
endinterface

// File: rtl/crc7_write.sv
// Serial CRC7 generator. Feeding back crc[6] as the input bit turns it into a
// plain left shift, which is how the writer clocks the checksum out.
module crc7_write
  import cmd_write_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_step(clear ? CRC_W'(0) : crc, bit_in);
    end else if (clear) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/cmd_write.sv
// SD command writer: serialises a 48-bit command frame onto the CMD line, then
// waits out a short gap before signalling completion and arming the receiver.
module cmd_write
  import cmd_write_pkg::*;
(
  input  logic         sd_clk_i,
  input  logic         rst_i,
  cmd_write_if.slave   bus
);

  sd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  cmd_req_t         req_q;
  logic             latch_en;

  logic cmd_q, cmd_d;
  logic en_q, en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic listen_q, listen_d;

  logic             crc_clear, crc_en, crc_bit, tx_bit;
  logic [CRC_W-1:0] crc;

  crc7_write u_crc (
    .clk    (sd_clk_i),
    .rst    (rst_i),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // Next state, and the line value for the cycle that follows this edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    latch_en  = 1'b0;
    cmd_d     = 1'b1;
    en_d      = 1'b0;
    done_d    = 1'b0;
    listen_d  = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = 1'b0;
    tx_bit    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_tx_i) begin
          state_d   = ST_TX;
          cnt_d     = '0;
          latch_en  = 1'b1;
          tx_bit    = frame_bit(CNT_W'(0), bus.cmd_index_i, bus.cmd_arg_i);
          cmd_d     = tx_bit;
          en_d      = 1'b1;
          crc_clear = 1'b1;
          crc_en    = 1'b1;
          crc_bit   = tx_bit;
        end
      end

      ST_TX: begin
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          en_d  = 1'b1;
          if (cnt_d < CNT_W'(CRC_START_BIT)) begin
            tx_bit  = frame_bit(cnt_d, req_q.index, req_q.arg);
            cmd_d   = tx_bit;
            crc_en  = 1'b1;
            crc_bit = tx_bit;
          end else if (cnt_d <= CNT_W'(CRC_END_BIT)) begin
            // Shift the finished checksum out MSB first.
            cmd_d   = crc[CRC_W-1];
            crc_en  = 1'b1;
            crc_bit = crc[CRC_W-1];
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_LEN - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_d == GAP_W'(GAP_LEN - 1)) begin
            done_d   = 1'b1;
            listen_d = req_q.rsp_expected;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge sd_clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      req_q    <= '0;
      cmd_q    <= 1'b1;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      listen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      if (latch_en) begin
        req_q <= '{index: bus.cmd_index_i, arg: bus.cmd_arg_i,
                   rsp_expected: bus.rsp_expected_i};
      end
      cmd_q    <= cmd_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      listen_q <= listen_d;
    end
  end

  assign bus.cmd_o             = cmd_q;
  assign bus.cmd_en_o          = en_q;
  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.start_listening_o = listen_q;

endmodule

// File: tb/tb_cmd_write.sv
// Self-checking bench for cmd_write: known SD command vectors, disturbance,
// mid-frame reset, back-to-back and randomized frames against a frame model.
module tb_cmd_write;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  cmd_write_if bus ();

  cmd_write dut (
    .sd_clk_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame: 40-bit header, CRC7 (x^7+x^3+1, init 0) over it, end bit.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    logic [6:0]  crc;
    logic        fb;
    head = {2'b01, idx, arg};
    crc  = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = head[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'b0001001;
    end
    return {head, crc, 1'b1};
  endfunction

  // Issue one command and record what appears on the outputs for 56 cycles.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input logic rsp,
                           input bit disturb,
                           output logic [47:0] frame, output int en_cnt, output int first_en,
                           output int done_cnt, output int done_at,
                           output int listen_cnt, output int listen_at, output int busy_low);
    int nb;
    @(negedge clk);
    bus.start_tx_i     = 1'b1;
    bus.cmd_index_i    = idx;
    bus.cmd_arg_i      = arg;
    bus.rsp_expected_i = rsp;
    @(posedge clk);
    frame = '1; en_cnt = 0; first_en = -1; done_cnt = 0; done_at = -1;
    listen_cnt = 0; listen_at = -1; busy_low = 0; nb = 0;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      if (c == 1) bus.start_tx_i = 1'b0;
      if (bus.cmd_en_o === 1'b1) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
        if (nb < 48) begin
          frame[47 - nb] = bus.cmd_o;
          nb++;
        end
      end
      if (bus.done_o === 1'b1) begin done_cnt++; done_at = c; end
      if (bus.start_listening_o === 1'b1) begin listen_cnt++; listen_at = c; end
      if (c <= 50 && bus.busy_o !== 1'b1) busy_low++;
      if (disturb && c >= 2 && c <= 50) begin
        bus.cmd_index_i    = 6'($urandom);
        bus.cmd_arg_i      = $urandom;
        bus.rsp_expected_i = 1'($urandom);
        bus.start_tx_i     = (c == 10 || c == 30);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_tx_i = 1'b0; bus.cmd_index_i = '0; bus.cmd_arg_i = '0; bus.rsp_expected_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.cmd_o !== 1'b1) begin errors++; $display("FAIL reset_cmd got %b want 1", bus.cmd_o); end
    vectors++; if (bus.cmd_en_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", bus.cmd_en_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    vectors++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    vectors++; if (bus.start_listening_o !== 1'b0) begin errors++; $display("FAIL reset_listen got %b want 0", bus.start_listening_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd0();
    logic [47:0] f; int en, fe, dc, da, lc, la, bl;
    run_frame(6'd0, 32'h0, 1'b0, 1'b0, f, en, fe, dc, da, lc, la, bl);
    vectors++; if (f !== 48'h400000000095) begin errors++; $display("FAIL cmd0_frame got %h want 400000000095", f); end
    vectors++; if (fe !== 1) begin errors++; $display("FAIL cmd0_latency got %0d want 1", fe); end
    vectors++; if (da !== 50 || dc !== 1) begin errors++; $display("FAIL cmd0_done got cycle %0d count %0d want 50/1", da, dc); end
    vectors++; if (lc !== 0) begin errors++; $display("FAIL cmd0_listen got %0d pulses want 0", lc); end
    vectors++; if (bl !== 0) begin errors++; $display("FAIL cmd0_busy got %0d low cycles want 0", bl); end
    vectors++; if (bus.busy_o !== 1'b0 || bus.cmd_o !== 1'b1) begin errors++; $display("FAIL cmd0_idle got busy %b cmd %b want 0/1", bus.busy_o, bus.cmd_o); end
  endtask

  task automatic test_cmd17();
    logic [47:0] f; int en, fe, dc, da, lc, la, bl;
    run_frame(6'd17, 32'h0, 1'b1, 1'b0, f, en, fe, dc, da, lc, la, bl);
    vectors++; if (f !== 48'h510000000055) begin errors++; $display("FAIL cmd17_frame got %h want 510000000055", f); end
    vectors++; if (la !== 50 || lc !== 1) begin errors++; $display("FAIL cmd17_listen got cycle %0d count %0d want 50/1", la, lc); end
    vectors++; if (da !== 50) begin errors++; $display("FAIL cmd17_done got cycle %0d want 50", da); end
  endtask

  task automatic test_cmd8();
    logic [47:0] f; int en, fe, dc, da, lc, la, bl;
    run_frame(6'd8, 32'h000001AA, 1'b1, 1'b0, f, en, fe, dc, da, lc, la, bl);
    vectors++; if (f !== 48'h48000001AA87) begin errors++; $display("FAIL cmd8_frame got %h want 48000001aa87", f); end
    vectors++; if (en !== 48) begin errors++; $display("FAIL cmd8_en_cycles got %0d want 48", en); end
  endtask

  task automatic test_ignore_start();
    logic [47:0] f; int en, fe, dc, da, lc, la, bl;
    logic [31:0] a;
    a = $urandom;
    run_frame(6'd17, a, 1'b0, 1'b1, f, en, fe, dc, da, lc, la, bl);
    vectors++; if (f !== model_frame(6'd17, a)) begin errors++; $display("FAIL ignore_frame got %h want %h", f, model_frame(6'd17, a)); end
    vectors++; if (bl !== 0) begin errors++; $display("FAIL ignore_busy got %0d low cycles want 0", bl); end
    vectors++; if (dc !== 1 || lc !== 0) begin errors++; $display("FAIL ignore_pulses got done %0d listen %0d want 1/0", dc, lc); end
    vectors++; if (en !== 48) begin errors++; $display("FAIL ignore_en_cycles got %0d want 48", en); end
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] f; int en, fe, dc, da, lc, la, bl;
    int pulses;
    logic [5:0] i2; logic [31:0] a2;
    @(negedge clk);
    bus.start_tx_i = 1'b1; bus.cmd_index_i = 6'h2A; bus.cmd_arg_i = $urandom; bus.rsp_expected_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) bus.start_tx_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bus.cmd_o !== 1'b1 || bus.cmd_en_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL midrst_line got cmd %b en %b busy %b want 1/0/0", bus.cmd_o, bus.cmd_en_o, bus.busy_o);
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.start_listening_o === 1'b1 || bus.cmd_en_o === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", pulses); end
    i2 = 6'($urandom); a2 = $urandom;
    run_frame(i2, a2, 1'b0, 1'b0, f, en, fe, dc, da, lc, la, bl);
    vectors++; if (f !== model_frame(i2, a2)) begin errors++; $display("FAIL midrst_next_frame got %h want %h", f, model_frame(i2, a2)); end
    vectors++; if (da !== 50) begin errors++; $display("FAIL midrst_next_done got cycle %0d want 50", da); end
  endtask

  task automatic test_back_to_back();
    logic line [1:104];
    logic en [1:104];
    logic [47:0] f1, f2, exp_f;
    int en_ok, gap_ok, dc;
    logic [5:0] idx; logic [31:0] arg;
    idx = 6'($urandom); arg = $urandom; exp_f = model_frame(idx, arg);
    @(negedge clk);
    bus.start_tx_i = 1'b1; bus.cmd_index_i = idx; bus.cmd_arg_i = arg; bus.rsp_expected_i = 1'b0;
    @(posedge clk);
    dc = 0;
    for (int c = 1; c <= 104; c++) begin
      @(negedge clk);
      line[c] = bus.cmd_o; en[c] = bus.cmd_en_o;
      if (bus.done_o === 1'b1) dc++;
      if (c == 60) bus.start_tx_i = 1'b0;
    end
    en_ok = 0; gap_ok = 0;
    for (int k = 0; k < 48; k++) begin
      f1[47 - k] = line[1 + k];
      f2[47 - k] = line[52 + k];
      if (en[1 + k] === 1'b1) en_ok++;
      if (en[52 + k] === 1'b1) en_ok++;
    end
    for (int c = 49; c <= 51; c++) if (en[c] === 1'b0 && line[c] === 1'b1) gap_ok++;
    vectors++; if (f1 !== exp_f) begin errors++; $display("FAIL b2b_frame1 got %h want %h", f1, exp_f); end
    vectors++; if (f2 !== exp_f) begin errors++; $display("FAIL b2b_frame2 got %h want %h", f2, exp_f); end
    vectors++; if (en_ok !== 96) begin errors++; $display("FAIL b2b_en got %0d enabled cycles want 96", en_ok); end
    vectors++; if (gap_ok !== 3) begin errors++; $display("FAIL b2b_gap got %0d idle-high cycles want 3", gap_ok); end
    vectors++; if (dc !== 2) begin errors++; $display("FAIL b2b_done got %0d pulses want 2", dc); end
    vectors++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_final_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_random();
    logic [47:0] f; int en, fe, dc, da, lc, la, bl;
    logic [5:0] idx; logic [31:0] arg; logic rsp;
    for (int n = 0; n < 8; n++) begin
      idx = 6'($urandom); arg = $urandom; rsp = 1'($urandom);
      run_frame(idx, arg, rsp, 1'b0, f, en, fe, dc, da, lc, la, bl);
      vectors++; if (f !== model_frame(idx, arg)) begin errors++; $display("FAIL rand%0d_frame got %h want %h", n, f, model_frame(idx, arg)); end
      vectors++; if (en !== 48 || fe !== 1) begin errors++; $display("FAIL rand%0d_en got %0d from %0d want 48 from 1", n, en, fe); end
      vectors++; if (da !== 50 || lc !== int'(rsp)) begin errors++; $display("FAIL rand%0d_pulses got done %0d listen %0d want 50/%0d", n, da, lc, rsp); end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_cmd0();
    test_cmd17();
    test_cmd8();
    test_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
